// File: rtl/cv32e40p_mult_arbiter.sv
// rtl/cv32e40p_mult_arbiter.sv - round-robin arbiter sharing one cv32e40p_mult between NUM_REQ requesters
//
// Purpose: grants one requester at a time, latches its control word and operands,
// drives the mult until it reports ready, then holds the result for the owner.
// Optional feature macro: CV32E40P_MULT_ARB_BYPASS_EN (re-arbitrate in the response
// handshake cycle so back-to-back ops issue every 2 cycles instead of 3).
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   flush_i                      abort in-flight op and drop pending response
//   req_valid_i / req_ready_o    per-requester request handshake
//   req_ctrl_i, req_op_[abc]_i   packed per-requester control word and operands
//   resp_valid_o / resp_ready_i  per-requester response handshake
//   resp_result_o                shared result bus
//   mult_*                       connection to the cv32e40p_mult instance
module cv32e40p_mult_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_op_a_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_op_b_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_op_c_i,
  output logic [NUM_REQ-1:0]        resp_valid_o,
  input  logic [NUM_REQ-1:0]        resp_ready_i,
  output logic [DATA_W-1:0]         resp_result_o,
  output logic                      mult_enable_o,
  output logic [CTRL_W-1:0]         mult_ctrl_o,
  output logic [DATA_W-1:0]         mult_op_a_o,
  output logic [DATA_W-1:0]         mult_op_b_o,
  output logic [DATA_W-1:0]         mult_op_c_o,
  input  logic [DATA_W-1:0]         mult_result_i,
  input  logic                      mult_ready_i,
  output logic                      mult_ex_ready_o,
  output logic                      mult_setback_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, rr_q, owner_inc;
  logic [IDX_W-1:0]    arb_base, winner, scan_idx;
  logic                win_found;
  logic                accept;
  logic                resp_hs;
  logic [DATA_W-1:0]   result_q;
  logic [CTRL_W-1:0]   ctrl_q;
  logic [DATA_W-1:0]   op_a_q, op_b_q, op_c_q;
  logic [NUM_REQ-1:0]  req_ready, resp_valid;
  logic                mult_enable, mult_ex_ready;

  assign owner_inc = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign resp_hs   = resp_ready_i[owner_q];

  // In RESP the scan starts just past the current owner, which is where rr_q is
  // about to point; only the bypass build ever accepts from RESP.
  assign arb_base = (state_q == RESP) ? owner_inc : rr_q;

  // Round-robin scan: first valid requester at or after arb_base, wrapping.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDX_W'((int'(arb_base) + k) % NUM_REQ);
      if (!win_found && req_valid_i[scan_idx]) begin
        winner    = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    req_ready     = '0;
    resp_valid    = '0;
    mult_enable   = 1'b0;
    mult_ex_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        mult_enable   = 1'b1;
        mult_ex_ready = mult_ready_i;
        if (mult_ready_i) state_d = RESP;
      end
      RESP: begin
        resp_valid[owner_q] = 1'b1;
        if (resp_hs) begin
          state_d = IDLE;
`ifdef CV32E40P_MULT_ARB_BYPASS_EN
          if (win_found) begin
            accept  = 1'b1;
            state_d = BUSY;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // A flush kills whatever is in flight, including a response not yet taken.
    if (flush_i) begin
      state_d    = IDLE;
      accept     = 1'b0;
      resp_valid = '0;
    end
    if (accept) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) owner_q <= winner;
      if (state_q == BUSY && mult_ready_i && !flush_i) result_q <= mult_result_i;
      if (state_q == RESP && resp_hs && !flush_i) rr_q <= owner_inc;
    end
  end

  // Operands are captured at accept so the requester is free to move on.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      op_c_q <= '0;
    end else if (accept) begin
      ctrl_q <= req_ctrl_i[int'(winner)*CTRL_W +: CTRL_W];
      op_a_q <= req_op_a_i[int'(winner)*DATA_W +: DATA_W];
      op_b_q <= req_op_b_i[int'(winner)*DATA_W +: DATA_W];
      op_c_q <= req_op_c_i[int'(winner)*DATA_W +: DATA_W];
    end
  end

  // Outputs are held low while reset is asserted, whatever state the flops hold.
  assign req_ready_o     = rst ? '0 : req_ready;
  assign resp_valid_o    = rst ? '0 : resp_valid;
  assign mult_enable_o   = mult_enable & ~rst;
  assign mult_ex_ready_o = mult_ex_ready & ~rst;
  assign mult_setback_o  = flush_i & ~rst;
  assign resp_result_o   = result_q;
  assign mult_ctrl_o     = ctrl_q;
  assign mult_op_a_o     = op_a_q;
  assign mult_op_b_o     = op_b_q;
  assign mult_op_c_o     = op_c_q;

endmodule

// File: tb/tb_cv32e40p_mult_arbiter.sv
// tb/tb_cv32e40p_mult_arbiter.sv - scoreboard bench for cv32e40p_mult_arbiter with a behavioural mult
module tb_cv32e40p_mult_arbiter;

  localparam logic [15:0] C_MUL  = 16'd0;
  localparam logic [15:0] C_MAC  = 16'd1;
  localparam logic [15:0] C_MULH = 16'd2;
`ifdef CV32E40P_MULT_ARB_BYPASS_EN
  localparam int ISSUE_GAP = 2;
`else
  localparam int ISSUE_GAP = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  req_valid, req_ready;
  logic [31:0] req_ctrl;
  logic [63:0] op_a, op_b, op_c;
  logic [1:0]  resp_valid, resp_ready;
  logic [31:0] resp_result;
  logic        mult_enable;
  logic [15:0] mult_ctrl;
  logic [31:0] m_a, m_b, m_c, m_res;
  logic        m_ready, m_ex_ready, m_setback;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int          owner;
    logic [31:0] res;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cv32e40p_mult_arbiter #(.NUM_REQ(2), .DATA_W(32), .CTRL_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_ctrl_i      (req_ctrl),
    .req_op_a_i      (op_a),
    .req_op_b_i      (op_b),
    .req_op_c_i      (op_c),
    .resp_valid_o    (resp_valid),
    .resp_ready_i    (resp_ready),
    .resp_result_o   (resp_result),
    .mult_enable_o   (mult_enable),
    .mult_ctrl_o     (mult_ctrl),
    .mult_op_a_o     (m_a),
    .mult_op_b_o     (m_b),
    .mult_op_c_o     (m_c),
    .mult_result_i   (m_res),
    .mult_ready_i    (m_ready),
    .mult_ex_ready_o (m_ex_ready),
    .mult_setback_o  (m_setback)
  );

  // Behavioural mult: MUL/MAC single cycle; MULH walks IDLE,STEP0,STEP1,STEP2,FINISH.
  logic [2:0]         m_cnt = 3'd0;
  int                 m_step0 = 0;
  logic signed [63:0] m_sprod;
  logic               m_is_mulh;

  assign m_is_mulh = (mult_ctrl[1:0] == 2'd2);
  assign m_ready   = !mult_enable || !m_is_mulh || (m_cnt == 3'd4);

  always_comb begin
    m_sprod = longint'($signed(m_a)) * longint'($signed(m_b));
    m_res   = 32'd0;
    case (mult_ctrl[1:0])
      2'd0:    m_res = m_a * m_b;
      2'd1:    m_res = m_a * m_b + m_c;
      2'd2:    m_res = m_sprod[63:32];
      default: m_res = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (rst || m_setback) m_cnt <= 3'd0;
    else if (mult_enable && m_is_mulh) begin
      if (m_cnt == 3'd4) begin
        if (m_ex_ready) m_cnt <= 3'd0;
      end else begin
        m_cnt <= m_cnt + 3'd1;
        if (m_cnt == 3'd0) m_step0 <= m_step0 + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  int acc_cyc[2];
  initial begin
    bit   in_resp = 0;
    int   first_cyc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        if (resp_valid != 2'b00) begin
          if (!in_resp) begin
            in_resp   = 1;
            first_cyc = cyc;
          end
          if ((resp_valid & resp_ready) != 2'b00) begin
            if (sbq.size() == 0) check("resp_unexpected", 64'(resp_valid), 64'd0);
            else begin
              e = sbq.pop_front();
              check("resp_owner", 64'(resp_valid), 64'(2'b01 << e.owner));
              check("resp_result", 64'(resp_result), 64'(e.res));
              if (e.lat > 0) check("resp_latency", 64'(first_cyc - acc_cyc[e.owner]), 64'(e.lat));
            end
            in_resp = 0;
          end
        end
        for (int i = 0; i < 2; i++)
          if (req_valid[i] && req_ready[i]) acc_cyc[i] = cyc;
      end
    end
  end

  task automatic issue(input int r, input logic [15:0] ctrl, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c, input logic [31:0] exp,
                       input int lat, input bit push, output int gcyc);
    int waited = 0;
    bit got = 0;
    gcyc = 0;
    @(negedge clk);
    req_ctrl[r*16 +: 16] = ctrl;
    op_a[r*32 +: 32] = a;
    op_b[r*32 +: 32] = b;
    op_c[r*32 +: 32] = c;
    req_valid[r] = 1'b1;
    #1;
    while (!got && waited < 50) begin
      if (req_ready[r]) got = 1;
      else begin
        @(negedge clk);
        #1;
        waited++;
      end
    end
    check("grant_seen", 64'(got), 64'd1);
    if (got) begin
      check("req_ready_onehot", 64'(req_ready), 64'(2'b01 << r));
      gcyc = cyc;
      if (push) sbq.push_back('{owner: r, res: exp, lat: lat});
    end
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic dual(input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] r0,
                      input logic [31:0] a1, input logic [31:0] b1, input logic [31:0] r1,
                      input int n, input int first);
    int g = 0;
    int waited = 0;
    int expo;
    int gc[8];
    @(negedge clk);
    req_ctrl  = {C_MUL, C_MUL};
    op_a      = {a1, a0};
    op_b      = {b1, b0};
    op_c      = 64'd0;
    req_valid = 2'b11;
    while (g < n && waited < 100) begin
      #1;
      if (req_ready != 2'b00) begin
        expo = (first + g) % 2;
        check("grant_order", 64'(req_ready), 64'(2'b01 << expo));
        sbq.push_back('{owner: expo, res: (expo == 1) ? r1 : r0, lat: 2});
        gc[g] = cyc;
        if (g > 0) check("issue_interval", 64'(gc[g] - gc[g-1]), 64'(ISSUE_GAP));
        g++;
      end
      if (g < n) begin
        @(negedge clk);
        waited++;
      end
    end
    if (g < n) check("dual_timeout", 64'(g), 64'(n));
    @(posedge clk);
    #1;
    req_valid = 2'b00;
  endtask

  task automatic drain();
    int w = 0;
    while ((sbq.size() != 0 || resp_valid != 2'b00) && w < 100) begin
      @(negedge clk);
      #4;
      w++;
    end
    check("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int g;
    int bad;
    int s0;
    rst = 1'b1; flush = 1'b0; req_valid = 2'b00; req_ctrl = 32'd0;
    op_a = 64'd0; op_b = 64'd0; op_c = 64'd0; resp_ready = 2'b11;

    // Reset: outputs low during reset and in the first cycle after it.
    repeat (2) @(negedge clk);
    req_valid = 2'b01;
    #1;
    check("reset_outputs", 64'({req_ready, resp_valid, mult_enable, m_ex_ready, m_setback}), 64'd0);
    @(posedge clk); #1; rst = 1'b0; req_valid = 2'b00;
    @(negedge clk); #1;
    check("post_reset_outputs", 64'({req_ready, resp_valid, mult_enable, m_ex_ready, m_setback}), 64'd0);
    check("post_reset_result", 64'(resp_result), 64'd0);

    // T1: MAC 3*5+7 on req0, then MUL 6*7 on req1 (leaves rr pointing at req0).
    issue(0, C_MAC, 32'd3, 32'd5, 32'd7, 32'd22, 2, 1, g);
    drain();
    issue(1, C_MUL, 32'd6, 32'd7, 32'd0, 32'd42, 2, 1, g);
    drain();

    // T2: both requesters held valid, grants alternate 0,1,0,1.
    dual(32'd2, 32'd3, 32'd6, 32'd4, 32'd5, 32'd20, 4, 0);
    drain();

    // T3: MULH signed on req1, result at +6, enable drops after FINISH.
    s0 = m_step0;
    issue(1, C_MULH, 32'h8000_0000, 32'd2, 32'd0, 32'hFFFF_FFFF, 6, 1, g);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (cyc == g + 5) check("mulh_enable_finish", 64'(mult_enable), 64'd1);
      if (cyc == g + 6) begin
        check("mulh_enable_after", 64'(mult_enable), 64'd0);
        check("mulh_resp_valid", 64'(resp_valid), 64'(2'b10));
      end
    end
    drain();
    check("mulh_single_step0", 64'(m_step0 - s0), 64'd1);

    // T4: flush at accept+3 during MULH on req0; no response, rr unchanged.
    issue(0, C_MULH, 32'd5, 32'd6, 32'd0, 32'd0, 0, 0, g);
    while (cyc < g + 3) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_setback", 64'(m_setback), 64'd1);
    @(posedge clk); #1; flush = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clk); #1;
      if (resp_valid != 2'b00 || mult_enable || m_setback) bad++;
    end
    check("flush_quiet", 64'(bad), 64'd0);
    @(negedge clk);
    req_valid = 2'b01; flush = 1'b1;
    #1;
    check("flush_blocks_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1; flush = 1'b0; req_valid = 2'b00;
    @(negedge clk); #1;
    check("flush_no_accept", 64'(mult_enable), 64'd0);
    dual(32'd2, 32'd2, 32'd4, 32'd3, 32'd3, 32'd9, 2, 0);
    drain();

    // T5: response stalled 10 cycles; output stable, no new accepts.
    resp_ready = 2'b00;
    issue(0, C_MUL, 32'd7, 32'd9, 32'd0, 32'd63, 2, 1, g);
    req_ctrl[31:16] = C_MUL; op_a[63:32] = 32'd10; op_b[63:32] = 32'd10;
    req_valid[1] = 1'b1;
    while (cyc < g + 2) @(negedge clk);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (resp_valid != 2'b01 || resp_result != 32'd63 || req_ready != 2'b00) bad++;
      @(negedge clk);
    end
    check("stall_stable", 64'(bad), 64'd0);
    req_valid = 2'b00;
    resp_ready = 2'b11;
    issue(1, C_MUL, 32'd10, 32'd10, 32'd0, 32'd100, 2, 1, g);
    drain();

    // T6: reset while BUSY clears outputs and rr.
    issue(0, C_MUL, 32'd1, 32'd5, 32'd0, 32'd5, 2, 1, g);
    drain();
    issue(1, C_MULH, 32'd3, 32'd4, 32'd0, 32'd0, 0, 0, g);
    while (cyc < g + 2) @(negedge clk);
    rst = 1'b1; req_valid = 2'b11;
    #1;
    check("busy_reset_outputs", 64'({req_ready, resp_valid, mult_enable, m_ex_ready, m_setback}), 64'd0);
    @(posedge clk); #1; rst = 1'b0; req_valid = 2'b00;
    @(negedge clk); #1;
    check("after_busy_reset_outputs", 64'({req_ready, resp_valid, mult_enable, m_ex_ready, m_setback}), 64'd0);
    check("after_busy_reset_result", 64'(resp_result), 64'd0);
    dual(32'd8, 32'd8, 32'd64, 32'd9, 32'd9, 32'd81, 2, 0);
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
